// File: rtl/dcache_tag_pkg.sv
// Shared definitions for the dcache tag controller: widths, entry field
// positions, FSM state encoding and the entry packing helper.
package dcache_tag_pkg;

  localparam int ADDR_W      = 32;
  localparam int INDEX_W     = 5;
  localparam int OFFSET_W    = 5;
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int ENTRY_W     = 26;
  localparam int NUM_ENTRIES = 32;

  // Entry layout: [21:0] tag, [22] dirty, [23] valid, [25:24] reserved
  localparam int TAG_LSB   = 0;
  localparam int TAG_MSB   = TAG_W - 1;
  localparam int DIRTY_BIT = 22;
  localparam int VALID_BIT = 23;

  // Address field positions
  localparam int IDX_LSB  = OFFSET_W;
  localparam int IDX_MSB  = OFFSET_W + INDEX_W - 1;
  localparam int ATAG_LSB = OFFSET_W + INDEX_W;
  localparam int ATAG_MSB = ADDR_W - 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Build a RAM word; reserved bits are always written as zero
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic             vbit,
                                                    input logic             dirty,
                                                    input logic [TAG_W-1:0] tag);
    return {2'b00, vbit, dirty, tag};
  endfunction

endpackage

// File: rtl/dcache_tag_cmp.sv
// Combinational decode of one tag RAM entry plus the hit compare against the
// lookup tag. Reserved entry bits are ignored.
module dcache_tag_cmp
  import dcache_tag_pkg::*;
(
  input  logic [ENTRY_W-1:0] entry_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               hit_o,
  output logic               dirty_o,
  output logic               valid_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic reserved_unused;

  // Split the entry into its fields and compare the stored tag
  always_comb begin
    tag_o           = entry_i[TAG_MSB:TAG_LSB];
    dirty_o         = entry_i[DIRTY_BIT];
    valid_o         = entry_i[VALID_BIT];
    hit_o           = entry_i[VALID_BIT] & (entry_i[TAG_MSB:TAG_LSB] == tag_i);
    reserved_unused = ^entry_i[ENTRY_W-1:VALID_BIT+1];
  end

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Dcache tag RAM controller: drives both RAM ports, performs lookup + hit
// compare, applies line-state updates and invalidates all entries after reset
// and on flush (the RAM array itself has no reset).
// Optional build macro DCACHE_TAG_BYPASS_EN: a same-index update+lookup pair is
// accepted together and the response is taken from the update data instead of
// stalling the lookup.
module dcache_tag_ctrl
  import dcache_tag_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lookup_valid_i,
  input  logic [ADDR_W-1:0]   lookup_addr_i,
  output logic                lookup_ready_o,
  output logic                resp_valid_o,
  output logic                resp_hit_o,
  output logic                resp_dirty_o,
  output logic                resp_valid_line_o,
  output logic [TAG_W-1:0]    resp_tag_o,
  output logic [INDEX_W-1:0]  resp_index_o,
  input  logic                update_valid_i,
  input  logic [INDEX_W-1:0]  update_index_i,
  input  logic [TAG_W-1:0]    update_tag_i,
  input  logic                update_vbit_i,
  input  logic                update_dirty_i,
  output logic                update_ready_o,
  input  logic                flush_i,
  output logic                flush_busy_o,
  output logic                ram_csb0_o,
  output logic [INDEX_W-1:0]  ram_addr0_o,
  output logic [ENTRY_W-1:0]  ram_din0_o,
  output logic                ram_csb1_o,
  output logic [INDEX_W-1:0]  ram_addr1_o,
  input  logic [ENTRY_W-1:0]  ram_dout1_i
);

  state_e               state_q, state_d;
  logic [INDEX_W-1:0]   cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [TAG_W-1:0]     ltag_q, ltag_d;
  logic [INDEX_W-1:0]   lidx_q, lidx_d;
  logic                 byp_q, byp_d;
  logic [ENTRY_W-1:0]   byp_entry_q, byp_entry_d;

  logic [INDEX_W-1:0]   lk_index_s;
  logic                 same_idx_s;
  logic                 lk_acc_s;
  logic [ENTRY_W-1:0]   resp_entry_s;
  logic                 cmp_hit_s, cmp_dirty_s, cmp_valid_s;
  logic [TAG_W-1:0]     cmp_tag_s;
  logic                 offset_unused;

  assign lk_index_s    = lookup_addr_i[IDX_MSB:IDX_LSB];
  assign same_idx_s    = (update_index_i == lk_index_s);
  assign offset_unused = ^lookup_addr_i[OFFSET_W-1:0];

  // FSM next state, acceptance decisions and RAM port drive
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lookup_ready_o = 1'b0;
    update_ready_o = 1'b0;
    flush_busy_o   = 1'b0;
    ram_csb0_o     = 1'b1;
    ram_addr0_o    = '0;
    ram_din0_o     = '0;
    ram_csb1_o     = 1'b1;
    ram_addr1_o    = '0;
    lk_acc_s       = 1'b0;
    byp_d          = 1'b0;
    if (rst_i) begin
      flush_busy_o = 1'b1;
      state_d      = ST_INIT;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_INIT, ST_FLUSH: begin
          flush_busy_o = 1'b1;
          ram_csb0_o   = 1'b0;
          ram_addr0_o  = cnt_q;
          ram_din0_o   = '0;
          cnt_d        = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            update_ready_o = 1'b1;
`ifdef DCACHE_TAG_BYPASS_EN
            lookup_ready_o = 1'b1;
`else
            // stall the lookup so the RAM never reads and writes one address together
            lookup_ready_o = ~(update_valid_i & same_idx_s);
`endif
            if (update_valid_i) begin
              ram_csb0_o  = 1'b0;
              ram_addr0_o = update_index_i;
              ram_din0_o  = pack_entry(update_vbit_i, update_dirty_i, update_tag_i);
            end else begin
              ram_csb0_o  = 1'b1;
            end
            if (lookup_valid_i && lookup_ready_o) begin
              lk_acc_s = 1'b1;
              if (update_valid_i && same_idx_s) begin
                // only reachable with bypass: answer from the update data
                byp_d = 1'b1;
              end else begin
                ram_csb1_o  = 1'b0;
                ram_addr1_o = lk_index_s;
              end
            end else begin
              lk_acc_s = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next-state values of the lookup response pipeline
  always_comb begin
    resp_valid_d = lk_acc_s;
    ltag_d       = ltag_q;
    lidx_d       = lidx_q;
    byp_entry_d  = byp_entry_q;
    if (lk_acc_s) begin
      ltag_d      = lookup_addr_i[ATAG_MSB:ATAG_LSB];
      lidx_d      = lk_index_s;
      byp_entry_d = pack_entry(update_vbit_i, update_dirty_i, update_tag_i);
    end else begin
      ltag_d = ltag_q;
    end
  end

  // State, counter and response registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      ltag_q       <= '0;
      lidx_q       <= '0;
      byp_q        <= 1'b0;
      byp_entry_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      ltag_q       <= ltag_d;
      lidx_q       <= lidx_d;
      byp_q        <= byp_d;
      byp_entry_q  <= byp_entry_d;
    end
  end

  // Response entry: RAM read data, or the captured update data on bypass
  always_comb begin
    if (byp_q) begin
      resp_entry_s = byp_entry_q;
    end else begin
      resp_entry_s = ram_dout1_i;
    end
  end

  dcache_tag_cmp u_cmp (
    .entry_i (resp_entry_s),
    .tag_i   (ltag_q),
    .hit_o   (cmp_hit_s),
    .dirty_o (cmp_dirty_s),
    .valid_o (cmp_valid_s),
    .tag_o   (cmp_tag_s)
  );

  // Response outputs, held at zero outside the one-cycle response pulse
  always_comb begin
    resp_valid_o      = resp_valid_q & ~rst_i;
    resp_hit_o        = 1'b0;
    resp_dirty_o      = 1'b0;
    resp_valid_line_o = 1'b0;
    resp_tag_o        = '0;
    resp_index_o      = '0;
    if (resp_valid_o) begin
      resp_hit_o        = cmp_hit_s;
      resp_dirty_o      = cmp_dirty_s;
      resp_valid_line_o = cmp_valid_s;
      resp_tag_o        = cmp_tag_s;
      resp_index_o      = lidx_q;
    end else begin
      resp_hit_o        = 1'b0;
    end
  end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Self-checking bench for dcache_tag_ctrl: directed scenarios followed by
// randomized traffic, checked every cycle against a line-level cache model.
module tb_dcache_tag_ctrl;

`ifdef DCACHE_TAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, lookup_valid_i, update_valid_i, update_vbit_i, update_dirty_i, flush_i;
  logic [31:0] lookup_addr_i;
  logic [4:0]  update_index_i;
  logic [21:0] update_tag_i;
  logic        lookup_ready_o, resp_valid_o, resp_hit_o, resp_dirty_o, resp_valid_line_o;
  logic [21:0] resp_tag_o;
  logic [4:0]  resp_index_o;
  logic        update_ready_o, flush_busy_o, ram_csb0_o, ram_csb1_o;
  logic [4:0]  ram_addr0_o, ram_addr1_o;
  logic [25:0] ram_din0_o, ram_dout1_i;

  always #5 clk_i = ~clk_i;

  dcache_tag_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i), .lookup_ready_o(lookup_ready_o),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_dirty_o(resp_dirty_o),
    .resp_valid_line_o(resp_valid_line_o), .resp_tag_o(resp_tag_o), .resp_index_o(resp_index_o),
    .update_valid_i(update_valid_i), .update_index_i(update_index_i), .update_tag_i(update_tag_i),
    .update_vbit_i(update_vbit_i), .update_dirty_i(update_dirty_i), .update_ready_o(update_ready_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o),
    .ram_csb0_o(ram_csb0_o), .ram_addr0_o(ram_addr0_o), .ram_din0_o(ram_din0_o),
    .ram_csb1_o(ram_csb1_o), .ram_addr1_o(ram_addr1_o), .ram_dout1_i(ram_dout1_i)
  );

  // Tag RAM model: no reset, inputs registered on posedge, read data after negedge
  logic [25:0] mem [32];
  logic [4:0]  rd_addr;
  logic        rd_pend = 1'b0;

  always @(posedge clk_i) begin
    if (!ram_csb0_o) mem[ram_addr0_o] <= ram_din0_o;
    if (!ram_csb1_o) begin
      rd_addr <= ram_addr1_o;
      rd_pend <= 1'b1;
    end else begin
      rd_pend <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (rd_pend) ram_dout1_i <= mem[rd_addr];
    else         ram_dout1_i <= 26'($urandom);
  end

  // Reference model: line contents, invalidation progress, pending response
  logic [21:0] m_tag [32];
  bit          m_v [32];
  bit          m_d [32];
  int          busy_left = 32;
  bit          p_valid = 1'b0;
  bit          p_hit, p_dirty, p_vline;
  logic [21:0] p_tag;
  int          p_idx;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit fl, input bit uv, input int ui,
                       input logic [21:0] ut, input bit uvb, input bit ud,
                       input bit lv, input logic [31:0] la);
    bit busy, ua, lacc, byp, same, rdy_l, wr;
    int li;
    logic [21:0] ltag;
    logic [31:0] exp_addr0, exp_din0;
    @(posedge clk_i); #1;
    rst_i = rst; flush_i = fl;
    update_valid_i = uv; update_index_i = ui[4:0]; update_tag_i = ut;
    update_vbit_i = uvb; update_dirty_i = ud;
    lookup_valid_i = lv; lookup_addr_i = la;
    #1;
    li   = int'(la[9:5]);
    ltag = la[31:10];
    busy = rst || (busy_left > 0);
    same = (ui == li);
    rdy_l = !busy && !fl && (BYP || !(uv && same));
    ua   = !busy && !fl && uv;
    lacc = rdy_l && lv;
    byp  = lacc && ua && same;
    wr   = (!rst && busy_left > 0) || ua;
    exp_addr0 = 0;
    exp_din0  = 0;
    if (wr && !ua) exp_addr0 = 32 - busy_left;
    if (ua) begin
      exp_addr0 = ui;
      exp_din0  = {6'd0, uvb, ud, ut};
    end
    check_eq("flush_busy", flush_busy_o, busy);
    check_eq("update_ready", update_ready_o, !busy && !fl);
    check_eq("lookup_ready", lookup_ready_o, rdy_l);
    check_eq("csb0", ram_csb0_o, !wr);
    check_eq("addr0", ram_addr0_o, exp_addr0);
    check_eq("din0", ram_din0_o, exp_din0);
    check_eq("csb1", ram_csb1_o, !(lacc && !byp));
    check_eq("addr1", ram_addr1_o, (lacc && !byp) ? li : 0);
    @(negedge clk_i); #1;
    check_eq("resp_valid", resp_valid_o, p_valid && !rst);
    if (p_valid && !rst) begin
      check_eq("resp_hit", resp_hit_o, p_hit);
      check_eq("resp_dirty", resp_dirty_o, p_dirty);
      check_eq("resp_vline", resp_valid_line_o, p_vline);
      check_eq("resp_tag", resp_tag_o, p_tag);
      check_eq("resp_index", resp_index_o, p_idx);
    end
    // advance the model to the state seen by the next cycle
    p_valid = lacc;
    if (lacc) begin
      p_idx = li;
      if (byp) begin
        p_vline = uvb; p_dirty = ud; p_tag = ut;
      end else begin
        p_vline = m_v[li]; p_dirty = m_d[li]; p_tag = m_tag[li];
      end
      p_hit = p_vline && (p_tag == ltag);
    end
    if (ua) begin
      m_v[ui] = uvb; m_d[ui] = ud; m_tag[ui] = ut;
    end
    if (!rst && busy_left > 0) begin
      m_v[32 - busy_left] = 1'b0; m_d[32 - busy_left] = 1'b0; m_tag[32 - busy_left] = 22'd0;
      busy_left--;
    end
    if (rst || (!busy && fl)) busy_left = 32;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 22'd0, 0, 0, 0, 32'd0);
  endtask

  task automatic look(input logic [31:0] a);
    cycle(0, 0, 0, 0, 22'd0, 0, 0, 1, a);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 26'($urandom);
      m_tag[i] = 22'($urandom); m_v[i] = 1'b1; m_d[i] = 1'b1;
    end
    rst_i = 1'b1; flush_i = 0; update_valid_i = 0; update_index_i = 0; update_tag_i = 0;
    update_vbit_i = 0; update_dirty_i = 0; lookup_valid_i = 0; lookup_addr_i = 0;
    // reset, then full INIT sweep
    cycle(1, 0, 0, 0, 22'd0, 0, 0, 1, 32'h1040);
    cycle(1, 0, 0, 0, 22'd0, 0, 0, 0, 32'd0);
    idle(33);
    look(32'h0000_1040);
    idle(1);
    // update then lookup on the next cycle
    cycle(0, 0, 1, 2, 22'h4, 1, 0, 0, 32'd0);
    look(32'h0000_1040);
    idle(1);
    // same-index update and lookup together
    cycle(0, 0, 1, 2, 22'h4, 1, 0, 1, 32'h0000_1040);
    look(32'h0000_1040);
    idle(1);
    // different indices accepted together
    cycle(0, 0, 1, 3, 22'h4, 1, 1, 1, 32'h0000_1040);
    look(32'h0000_1060);
    idle(1);
    // flush with a lookup right before it, and a re-pulse mid-flush
    look(32'h0000_1040);
    cycle(0, 1, 1, 5, 22'h7, 1, 1, 1, 32'h0000_1040);
    idle(9);
    cycle(0, 1, 0, 0, 22'd0, 0, 0, 0, 32'd0);
    idle(23);
    look(32'h0000_1040);
    idle(1);
    // reset in the middle of a flush
    cycle(0, 0, 1, 2, 22'h4, 1, 0, 0, 32'd0);
    cycle(0, 1, 0, 0, 22'd0, 0, 0, 0, 32'd0);
    idle(15);
    cycle(1, 0, 0, 0, 22'd0, 0, 0, 0, 32'd0);
    idle(33);
    look(32'h0000_1040);
    // randomized traffic with a small tag pool to produce hits
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)),
            22'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 2) != 0),
            {20'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom)} + 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
